// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider (div_int64_seq).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 64;
  localparam int CNT_W_DEFAULT = $clog2(DEFAULT_WIDTH);

  localparam int IMPL_RIPPLE = 0;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract
// the divisor over WIDTH+1 bits and keep the difference only when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int IMPL_TYPE = IMPL_RIPPLE
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;

  assign w_shifted = {i_rem, i_bit};

  generate
    if (IMPL_TYPE == IMPL_RIPPLE) begin : g_ripple
      logic [WIDTH:0] w_borrow;
      assign w_borrow[0] = 1'b0;
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign w_diff[gi]       = w_shifted[gi] ^ i_divisor[gi] ^ w_borrow[gi];
        assign w_borrow[gi + 1] = (~w_shifted[gi] & i_divisor[gi]) |
                                  (~(w_shifted[gi] ^ i_divisor[gi]) & w_borrow[gi]);
      end
      // Divisor's extra top bit is zero, so the final borrow only survives a zero MSB.
      assign w_lt = ~w_shifted[WIDTH] & w_borrow[WIDTH];
    end else begin : g_behav
      assign w_lt   = (w_shifted < {1'b0, i_divisor});
      assign w_diff = w_shifted[WIDTH-1:0] - i_divisor;
    end
  endgenerate

  assign o_qbit = ~w_lt;
  assign o_rem  = o_qbit ? w_diff : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/div_int64_seq.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional signed mode (truncating toward zero) enabled by defining DIV_INT64_SIGNED_EN.
module div_int64_seq
  import div_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int IMPL_TYPE = IMPL_RIPPLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dbz;

  logic             w_accept;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_qbit;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_b_zero = (B == '0);
  assign w_accept = in_valid && in_ready;

  div_step #(
    .WIDTH    (WIDTH),
    .IMPL_TYPE(IMPL_TYPE)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[WIDTH-1]),
    .i_divisor(r_div),
    .o_rem    (w_step_rem),
    .o_qbit   (w_step_qbit)
  );

  assign w_quo_next = {r_quo[WIDTH-2:0], w_step_qbit};

`ifdef DIV_INT64_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // Core works on magnitudes; MIN stays MIN, which is its correct unsigned magnitude.
  assign w_a_mag = A[WIDTH-1] ? -A : A;
  assign w_b_mag = B[WIDTH-1] ? -B : B;
  assign w_q_fin = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_fin = r_neg_r ? -w_step_rem : w_step_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept && !w_b_zero) begin
      r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      r_neg_r <= A[WIDTH-1];
    end
  end
`else
  assign w_a_mag = A;
  assign w_b_mag = B;
  assign w_q_fin = w_quo_next;
  assign w_r_fin = w_step_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = w_b_zero ? DONE : BUSY;
      end
      BUSY: begin
        if (r_cnt == '0) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      if (w_b_zero) begin
        // Divide-by-zero bypasses the core; R carries the raw dividend, sign included.
        r_q_out <= '1;
        r_r_out <= A;
        r_dbz   <= 1'b1;
      end else begin
        r_quo <= w_a_mag;
        r_div <= w_b_mag;
        r_rem <= '0;
        r_cnt <= CNT_LOAD;
      end
    end else if (r_state == BUSY) begin
      r_quo <= w_quo_next;
      r_rem <= w_step_rem;
      r_cnt <= r_cnt - CNT_ONE;
      if (r_cnt == '0) begin
        r_q_out <= w_q_fin;
        r_r_out <= w_r_fin;
        r_dbz   <= 1'b0;
      end
    end
  end

  assign Q           = r_q_out;
  assign R           = r_r_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_int64_seq.sv
// Directed self-checking bench for div_int64_seq (WIDTH=64); signed cases when DIV_INT64_SIGNED_EN is defined.
module tb_div_int64_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] Q;
  logic [63:0] R;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;

  div_int64_seq #(.WIDTH(64), .IMPL_TYPE(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_accept(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_ready);
    n = 0;
    busy_ready = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
      if (in_ready) busy_ready++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (Q !== 64'd0 || R !== 64'd0) begin failures++; $display("FAIL reset_qr: Q=%h R=%h required 0", Q, R); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b required 0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_basic();
    int n, br;
    do_accept(64'd100, 64'd7);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_after_accept: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid); end
    A = 64'd9; B = 64'd3; in_valid = 1'b1;
    wait_done(n, br);
    in_valid = 1'b0;
    checks++; if (n !== 64) begin failures++; $display("FAIL basic_latency: got %0d required 64", n); end
    checks++; if (br !== 0) begin failures++; $display("FAIL basic_busy_ready: in_ready high %0d cycles required 0", br); end
    checks++; if (Q !== 64'd14 || R !== 64'd2) begin failures++; $display("FAIL basic_result: Q=%0d R=%0d required 14/2", Q, R); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL basic_dbz: got %b required 0", div_by_zero); end
    consume();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_return_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid); end
    $display("basic: 100/7 -> Q=%0d R=%0d latency=%0d", Q, R, n);
  endtask

  task automatic test_wide();
    int n, br;
    do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000);
    wait_done(n, br);
    checks++; if (Q !== 64'hFFFF_FFFF || R !== 64'hFFFF_FFFF) begin failures++; $display("FAIL wide_result: Q=%h R=%h required ffffffff/ffffffff", Q, R); end
    consume();
    $display("wide: max/2^32 -> Q=%h R=%h", Q, R);
    do_accept(64'd5, 64'd9);
    wait_done(n, br);
    checks++; if (Q !== 64'd0 || R !== 64'd5) begin failures++; $display("FAIL small_result: Q=%0d R=%0d required 0/5", Q, R); end
    consume();
    $display("wide: 5/9 -> Q=%0d R=%0d", Q, R);
  endtask

  task automatic test_div_zero();
    int n, br;
    do_accept(64'd1234, 64'd0);
    wait_done(n, br);
    checks++; if (n !== 1) begin failures++; $display("FAIL dz_latency: got %0d required 1", n); end
    checks++; if (Q !== 64'hFFFF_FFFF_FFFF_FFFF || R !== 64'd1234) begin failures++; $display("FAIL dz_result: Q=%h R=%0d required all-ones/1234", Q, R); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag: got %b required 1", div_by_zero); end
    consume();
    $display("div_zero: 1234/0 -> Q=%h R=%0d dbz=%b", Q, R, div_by_zero);
  endtask

  task automatic test_edges();
    int n, br;
    do_accept(64'd0, 64'd5);
    wait_done(n, br);
    checks++; if (Q !== 64'd0 || R !== 64'd0) begin failures++; $display("FAIL zero_dividend: Q=%0d R=%0d required 0/0", Q, R); end
    consume();
    $display("edges: 0/5 -> Q=%0d R=%0d", Q, R);
    do_accept(64'hDEAD_BEEF, 64'd1);
    wait_done(n, br);
    checks++; if (Q !== 64'hDEAD_BEEF || R !== 64'd0) begin failures++; $display("FAIL div_by_one: Q=%h R=%h required deadbeef/0", Q, R); end
    consume();
    $display("edges: deadbeef/1 -> Q=%h R=%0d", Q, R);
  endtask

  task automatic test_backpressure();
    int n, br, bad;
    do_accept(64'd200, 64'd6);
    wait_done(n, br);
    bad = 0;
    A = 64'd1; B = 64'd1; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (Q !== 64'd33 || R !== 64'd2 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable: %0d unstable cycles required 0", bad); end
    consume();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release: in_ready=%b required 1", in_ready); end
    do_accept(64'd50, 64'd5);
    wait_done(n, br);
    checks++; if (n !== 64 || Q !== 64'd10 || R !== 64'd0) begin failures++; $display("FAIL hold_next_op: latency=%0d Q=%0d R=%0d required 64/10/0", n, Q, R); end
    consume();
    $display("backpressure: 200/6 held 10 cycles, then 50/5 -> Q=%0d R=%0d", Q, R);
  endtask

  task automatic test_ready_early();
    int n, br;
    out_ready = 1'b1;
    do_accept(64'd77, 64'd7);
    wait_done(n, br);
    checks++; if (Q !== 64'd11 || R !== 64'd0) begin failures++; $display("FAIL early_result: Q=%0d R=%0d required 11/0", Q, R); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL early_consume: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid); end
    out_ready = 1'b0;
    $display("ready_early: 77/7 -> Q=%0d R=%0d consumed on first DONE cycle", Q, R);
  endtask

  task automatic test_abort();
    int n, br;
    do_accept(64'd1000, 64'd3);
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (Q !== 64'd0 || R !== 64'd0 || div_by_zero !== 1'b0) begin failures++; $display("FAIL abort_outputs: Q=%0d R=%0d dbz=%b required 0/0/0", Q, R, div_by_zero); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL abort_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_accept(64'd81, 64'd9);
    wait_done(n, br);
    checks++; if (n !== 64 || Q !== 64'd9 || R !== 64'd0) begin failures++; $display("FAIL abort_fresh: latency=%0d Q=%0d R=%0d required 64/9/0", n, Q, R); end
    consume();
    $display("abort: reset at step 30, then 81/9 -> Q=%0d R=%0d", Q, R);
  endtask

`ifdef DIV_INT64_SIGNED_EN
  task automatic test_signed();
    int n, br;
    do_accept(64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_done(n, br);
    checks++; if (Q !== 64'hFFFF_FFFF_FFFF_FFFD || R !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL signed_neg_pos: Q=%h R=%h required -3/-1", Q, R); end
    consume();
    $display("signed: -7/2 -> Q=%h R=%h", Q, R);
    do_accept(64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done(n, br);
    checks++; if (Q !== 64'hFFFF_FFFF_FFFF_FFFD || R !== 64'd1) begin failures++; $display("FAIL signed_pos_neg: Q=%h R=%h required -3/1", Q, R); end
    consume();
    $display("signed: 7/-2 -> Q=%h R=%h", Q, R);
    do_accept(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(n, br);
    checks++; if (Q !== 64'h8000_0000_0000_0000 || R !== 64'd0) begin failures++; $display("FAIL signed_overflow: Q=%h R=%h required 8000000000000000/0", Q, R); end
    consume();
    $display("signed: MIN/-1 -> Q=%h R=%h", Q, R);
    do_accept(64'hFFFF_FFFF_FFFF_FFFB, 64'd0);
    wait_done(n, br);
    checks++; if (Q !== 64'hFFFF_FFFF_FFFF_FFFF || R !== 64'hFFFF_FFFF_FFFF_FFFB || div_by_zero !== 1'b1) begin failures++; $display("FAIL signed_dz: Q=%h R=%h dbz=%b required -1/-5/1", Q, R, div_by_zero); end
    consume();
    $display("signed: -5/0 -> Q=%h R=%h dbz=%b", Q, R, div_by_zero);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifndef DIV_INT64_SIGNED_EN
    test_wide();
`endif
    test_div_zero();
    test_edges();
    test_backpressure();
    test_ready_early();
    test_abort();
`ifdef DIV_INT64_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
